// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Turns a raw, asynchronous, bouncing push-button level into a
//             clean debounced level plus single-cycle press/release strobes.
//             The raw input is first synchronised, then a four-state FSM
//             requires the new level to persist for a full debounce window
//             before it is accepted.
//  Ports    : clock      in  - system clock, all logic on the rising edge
//             reset      in  - synchronous, active-high reset
//             button_in  in  - raw asynchronous button level (1 = pressed)
//             button_out out - debounced button level (registered)
//             pressed    out - one-cycle pulse on accepted 0->1 (registered)
//             released   out - one-cycle pulse on accepted 1->0 (registered)
//  Config   : BUTTON_DEBOUNCER_RELEASE_PULSE_EN
//             defined   -> released pulse is generated
//             undefined -> released is tied to 0 (port kept)
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic pressed,
    output logic released
);

    localparam int c_DEBOUNCE_CYCLES = CLOCK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int c_CNT_W           = $clog2(c_DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Reject configurations the window counter or synchroniser cannot honour.
    if (c_DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("button_debouncer: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_w;
    state_t                 state_q,   state_d;
    logic [c_CNT_W-1:0]     cnt_q,     cnt_d;
    logic                   out_q,     out_d;
    logic                   pressed_q, pressed_d;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    logic                   released_q, released_d;
`endif

    // Only the last synchroniser flop is ever looked at by the FSM.
    assign sync_w = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        pressed_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        released_d = 1'b0;
`endif
        case (state_q)
            STABLE_LOW: begin
                if (sync_w) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                // A single opposite sample abandons the window entirely;
                // the counter is re-zeroed on the next entry.
                if (!sync_w) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d   = STABLE_HIGH;
                    out_d     = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_w) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_w) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = STABLE_LOW;
                    out_d   = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
                    released_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            pressed_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
            released_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], button_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            pressed_q <= pressed_d;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
            released_q <= released_d;
`endif
        end
    end

    assign button_out = out_q;
    assign pressed    = pressed_q;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    assign released   = released_q;
`else
    assign released   = 1'b0;
`endif

endmodule
`default_nettype wire
